// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified RAM between instruction fetch and load/store.
// Each access is IDLE grant -> MEM_LAT busy cycles -> one DONE cycle with a ready pulse.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              if_stall_o,
  output logic              pipe_stall_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              stale_q;
  logic              is_mem_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic              ram_en_q;
  logic              ram_we_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stale_q     <= 1'b0;
      is_mem_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Data side is the older instruction, so it wins a tie; rd+wr counts as a write.
          if (mem_rd_i || mem_wr_i) begin
            state_q  <= MEM_BUSY;
            is_mem_q <= 1'b1;
            we_q     <= mem_wr_i;
            addr_q   <= mem_addr_i;
            wdata_q  <= mem_wdata_i;
            cnt_q    <= CNT_INIT;
            stale_q  <= 1'b0;
            ram_en_q <= 1'b1;
            ram_we_q <= mem_wr_i;
          end else if (if_req_i) begin
            state_q  <= IF_BUSY;
            is_mem_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= if_addr_i;
            wdata_q  <= mem_wdata_i;
            cnt_q    <= CNT_INIT;
            stale_q  <= if_flush_i;
            ram_en_q <= 1'b1;
            ram_we_q <= 1'b0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (state_q == IF_BUSY && if_flush_i) stale_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q  <= DONE;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (is_mem_q) begin
              mem_rdata_q <= ram_rdata_i;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= ram_rdata_i;
              // A flush in the final busy cycle still makes this fetch stale.
              if_ready_q <= ~(stale_q | (state_q == IF_BUSY && if_flush_i));
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ready_o = mem_ready_q;

  assign pipe_stall_o = (mem_rd_i | mem_wr_i) & ~mem_ready_q;
  assign if_stall_o   = pipe_stall_o | (if_req_i & ~if_ready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: MEM_LAT=2 and MEM_LAT=1 instances share one stimulus,
// each checked every cycle against a cycle-offset transaction model plus directed literals.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;

  logic [1:0]    if_ready, mem_ready, ram_en, ram_we, if_stall, pipe_stall;
  logic [DW-1:0] if_rdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];
  logic [AW-1:0] ram_addr [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : 1;
    logic [31:0] ram [1024];

    unified_mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_rdata_o(if_rdata[g]), .if_ready_o(if_ready[g]),
      .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata[g]), .mem_ready_o(mem_ready[g]),
      .ram_en_o(ram_en[g]), .ram_we_o(ram_we[g]), .ram_addr_o(ram_addr[g]),
      .ram_wdata_o(ram_wdata[g]), .ram_rdata_i(ram_rdata[g]),
      .if_stall_o(if_stall[g]), .pipe_stall_o(pipe_stall[g])
    );

    // RAM model: combinational read, write committed mid-cycle.
    assign ram_rdata[g] = ram[ram_addr[g][11:2]];
    initial begin
      for (int i = 0; i < 1024; i++) ram[i] = init_val(32'(i * 4));
      forever begin
        @(negedge clk);
        if (ram_en[g] && ram_we[g]) ram[ram_addr[g][11:2]] = ram_wdata[g];
      end
    end

    // Transaction model: an access granted in cycle s is busy in s+1..s+LAT, completes at s+LAT+1.
    initial begin
      bit          act = 1'b0, who = 1'b0, we = 1'b0, st = 1'b0;
      int          start = 0, k;
      logic [31:0] a = '0, wd = '0;
      logic [31:0] mm [1024];
      logic        e_en, e_ifr, e_memr, e_ps, e_is;
      for (int i = 0; i < 1024; i++) mm[i] = init_val(32'(i * 4));
      wait (armed);
      forever begin
        @(negedge clk);
        k      = cyc - start;
        e_en   = act && k >= 1 && k <= LAT;
        e_ifr  = act && k == LAT + 1 && !who && !st;
        e_memr = act && k == LAT + 1 && who;
        e_ps   = (mem_rd | mem_wr) & ~e_memr;
        e_is   = e_ps | (if_req & ~e_ifr);
        chk($sformatf("m%0d_ram_en", g), ram_en[g], e_en);
        chk($sformatf("m%0d_ram_we", g), ram_we[g], e_en && we);
        chk($sformatf("m%0d_if_ready", g), if_ready[g], e_ifr);
        chk($sformatf("m%0d_mem_ready", g), mem_ready[g], e_memr);
        chk($sformatf("m%0d_pipe_stall", g), pipe_stall[g], e_ps);
        chk($sformatf("m%0d_if_stall", g), if_stall[g], e_is);
        if (e_en) chk($sformatf("m%0d_ram_addr", g), ram_addr[g], a);
        if (e_en && we) chk($sformatf("m%0d_ram_wdata", g), ram_wdata[g], wd);
        if (e_ifr) chk($sformatf("m%0d_if_rdata", g), if_rdata[g], mm[a[11:2]]);
        if (e_memr && !we) chk($sformatf("m%0d_mem_rdata", g), mem_rdata[g], mm[a[11:2]]);
        if (rst) act = 1'b0;
        else if (act) begin
          if (!who && k >= 1 && k <= LAT && if_flush) st = 1'b1;
          if (k == LAT + 1) begin
            if (we) mm[a[11:2]] = wd;
            act = 1'b0;
          end
        end else if (mem_rd || mem_wr) begin
          act = 1'b1; who = 1'b1; we = mem_wr; a = mem_addr; wd = mem_wdata; st = 1'b0; start = cyc;
        end else if (if_req) begin
          act = 1'b1; who = 1'b0; we = 1'b0; a = if_addr; st = if_flush; start = cyc;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) nxt();
  endtask

  initial begin
    bit         found;
    int         we_cnt;
    logic [8:0] pat0, pat1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ram_en", ram_en[g], 0);
      chk("rst_if_ready", if_ready[g], 0);
      chk("rst_mem_ready", mem_ready[g], 0);
      chk("rst_if_rdata", if_rdata[g], 0);
      chk("rst_ram_addr", ram_addr[g], 0);
    end
    idle(2);

    // Lone fetch of 0x40
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk); chk("t1_stall_c0", if_stall[0], 1); chk("t1_en_c0", ram_en[0], 0);
    nxt(); @(negedge clk); chk("t1_en_c1", ram_en[0], 1); chk("t1_addr_c1", ram_addr[0], 32'h40);
    nxt(); @(negedge clk); chk("t1_en_c2", ram_en[0], 1); chk("t1_stall_c2", if_stall[0], 1);
    nxt(); @(negedge clk);
    chk("t1_ready_c3", if_ready[0], 1); chk("t1_rdata_c3", if_rdata[0], 32'hA583FFBF);
    chk("t1_stall_c3", if_stall[0], 0); chk("t1_en_c3", ram_en[0], 0);
    nxt(); if_req = 1'b0;
    idle(6);

    // Simultaneous fetch and load: load first
    if_req = 1'b1; if_addr = 32'h40; mem_rd = 1'b1; mem_addr = 32'h100;
    @(negedge clk); chk("t2_pstall_c0", pipe_stall[0], 1);
    nxt(); @(negedge clk); chk("t2_addr_c1", ram_addr[0], 32'h100); chk("t2_pstall_c1", pipe_stall[0], 1);
    nxt(); @(negedge clk); chk("t2_pstall_c2", pipe_stall[0], 1);
    nxt(); @(negedge clk);
    chk("t2_mready_c3", mem_ready[0], 1); chk("t2_mrdata_c3", mem_rdata[0], 32'hA4C3FEFF);
    chk("t2_pstall_c3", pipe_stall[0], 0); chk("t2_iready_c3", if_ready[0], 0);
    nxt(); mem_rd = 1'b0; @(negedge clk); chk("t2_en_c4", ram_en[0], 0);
    nxt(); @(negedge clk); chk("t2_en_c5", ram_en[0], 1); chk("t2_addr_c5", ram_addr[0], 32'h40);
    nxt(); nxt(); @(negedge clk); chk("t2_iready_c7", if_ready[0], 1);
    nxt(); if_req = 1'b0;
    idle(6);

    // Store then load back
    mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_we[0]) begin
        we_cnt++;
        chk("t3_wdata", ram_wdata[0], 32'hDEADBEEF);
      end
      nxt();
      mem_wr = 1'b0;
    end
    chk("t3_we_cycles", we_cnt, 2);
    idle(4);
    mem_rd = 1'b1; mem_addr = 32'h200;
    nxt(); mem_rd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_ready[0]) begin
        found = 1'b1;
        chk("t3_load", mem_rdata[0], 32'hDEADBEEF);
      end else nxt();
    end
    chk("t3_load_seen", found, 1);
    idle(6);

    // Flush during fetch of 0x40, re-served at 0x80
    if_req = 1'b1; if_addr = 32'h40;
    nxt(); if_flush = 1'b1; @(negedge clk); chk("t4_en_c1", ram_en[0], 1);
    nxt(); if_flush = 1'b0; if_addr = 32'h80;
    nxt(); @(negedge clk); chk("t4_noready_c3", if_ready[0], 0); chk("t4_stall_c3", if_stall[0], 1);
    nxt(); @(negedge clk); chk("t4_en_c4", ram_en[0], 0);
    nxt(); @(negedge clk); chk("t4_en_c5", ram_en[0], 1); chk("t4_addr_c5", ram_addr[0], 32'h80);
    nxt(); nxt(); @(negedge clk);
    chk("t4_ready_c7", if_ready[0], 1); chk("t4_rdata_c7", if_rdata[0], 32'hA543FF7F);
    nxt(); if_req = 1'b0;
    idle(6);

    // Reset in the middle of a load
    mem_rd = 1'b1; mem_addr = 32'h100;
    nxt(); mem_rd = 1'b0; rst = 1'b1; @(negedge clk); chk("t5_en_c1", ram_en[0], 1);
    nxt(); rst = 1'b0; @(negedge clk);
    chk("t5_en_c2", ram_en[0], 0); chk("t5_we_c2", ram_we[0], 0);
    chk("t5_mready_c2", mem_ready[0], 0); chk("t5_mrdata_c2", mem_rdata[0], 0);
    chk("t5_addr_c2", ram_addr[0], 0); chk("t5_pstall_c2", pipe_stall[0], 0);
    chk("t5_istall_c2", if_stall[0], 0);
    nxt(); @(negedge clk); chk("t5_mready_c3", mem_ready[0], 0);
    nxt(); @(negedge clk); chk("t5_mready_c4", mem_ready[0], 0);
    idle(6);

    // Back-to-back loads: ready every LAT+2 cycles
    mem_rd = 1'b1; mem_addr = 32'h100;
    pat0 = '0; pat1 = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pat0[i] = mem_ready[0];
      pat1[i] = mem_ready[1];
      nxt();
    end
    mem_rd = 1'b0;
    chk("t6_lat1_pattern", pat1, 9'h124);
    chk("t6_lat2_pattern", pat0, 9'h088);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data RAM between the IF stage (fetch) and the MEM stage (load/store).
- Sequences each RAM access over MEM_LAT cycles.
- Returns read data through per-requester ready pulses.
- Drives stall signals that the pipeline ORs with the hazard-unit PC_Write / IF_ID_PipeRegWrite controls.
- Sits between the pipeline top and the RAM model.

Parameters:
- MEM_LAT, 2, RAM access time in cycles; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  IF stage requests an instruction fetch.
- if_addr_i  in  ADDR_W  fetch address (PC).
- if_flush_i  in  1  branch taken; the in-flight fetch is stale.
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ready_o=1.
- if_ready_o  out  1  one-cycle fetch-complete pulse.
- mem_rd_i  in  1  load request.
- mem_wr_i  in  1  store request.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data; valid while mem_ready_o=1.
- mem_ready_o  out  1  one-cycle data-access-complete pulse.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data; valid in the last cycle of an access.
- if_stall_o  out  1  hold PC and IF/ID register.
- pipe_stall_o  out  1  freeze all stages (data access pending).

Behaviour:
- **Reset:** all outputs 0, state IDLE, counter 0, stale flag 0, captured address/data registers 0. Reset mid-access abandons it; no ready pulse is issued for it.
- **States:** IDLE, IF_BUSY, MEM_BUSY, DONE.
- **IDLE:**
  - mem_rd_i|mem_wr_i → MEM_BUSY; MEM has priority over IF because it is the older instruction.
  - else if_req_i → IF_BUSY.
  - On entry, latch the address, wdata, the write flag (mem_wr_i) and the requester ID into registers; counter := MEM_LAT-1.
  - mem_rd_i and mem_wr_i both high is illegal; it is treated as a write.
- **IF_BUSY / MEM_BUSY:**
  - ram_en_o=1, with ram_addr_o/ram_wdata_o driven from the latched registers for exactly MEM_LAT cycles.
  - ram_we_o=1 for all those cycles only when the latched write flag is set.
  - Counter decrements each cycle. When counter==0: capture ram_rdata_i into the requester's rdata register and go to DONE.
- **DONE (one cycle):**
  - ram_en_o=0.
  - Pulse the requester's ready, except: if the access was IF and stale=1, suppress if_ready_o.
  - Always → IDLE. No request is accepted in DONE.
  - Throughput: one access per MEM_LAT+2 cycles, counting IDLE.
- **Access is non-preemptive:** a MEM request arriving during IF_BUSY waits for that access to complete, then wins the next IDLE.
- **Latched inputs:** request inputs are latched at grant. Address changes during an access are ignored.
- **Stale flag:**
  - Set by if_flush_i while in IF_BUSY, or in IDLE on the cycle IF is granted.
  - Cleared on the IDLE entry of the next access.
  - A stale fetch still completes on the RAM; the IF requester, holding the new PC, is re-served later.
  - if_flush_i during MEM_BUSY has no effect on the MEM access.
- **Stalls (combinational):**
  - pipe_stall_o = (mem_rd_i|mem_wr_i) & ~mem_ready_o.
  - if_stall_o = pipe_stall_o | (if_req_i & ~if_ready_o).
- **Data outputs:** rdata registers hold their value until the next capture for that requester.
- **Counter width:** 4 bits.

Test Plan:
- MEM_LAT=2, lone fetch, if_addr_i=0x40 held at cycle 0 → ram_en_o=1 cycles 1-2 with ram_addr_o=0x40; if_ready_o=1 at cycle 3 with if_rdata_o=RAM[0x40]; if_stall_o=1 cycles 0-2, 0 at cycle 3.
- Simultaneous if_req_i and mem_rd_i (addr 0x100) in IDLE → MEM served first: mem_ready_o at cycle 3, then IF granted at cycle 4, if_ready_o at cycle 7; pipe_stall_o=1 cycles 0-2.
- Store: mem_wr_i, addr 0x200, wdata 0xDEADBEEF → ram_we_o=1 exactly 2 cycles; a later load of 0x200 returns 0xDEADBEEF.
- if_flush_i pulsed during IF_BUSY (fetch 0x40) → no if_ready_o for that fetch; new fetch at PC 0x80 starts in the next IDLE; if_ready_o carries RAM[0x80].
- rst_i asserted mid MEM_BUSY → next cycle all outputs 0, state IDLE; no mem_ready_o for the aborted access.
- MEM_LAT=1 → every access takes 3 cycles (IDLE grant, 1 busy, DONE); back-to-back loads produce mem_ready_o every 3 cycles.
